// File: rtl/alu_regfile_seq.sv
// GP register file on a shared tri-state bus feeding a sequencing ALU.
// Single-cycle ops plus multi-cycle shift-add MUL and shift-by-N, via start/busy/done.
module alu_regfile_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] main_bus,
    input  logic [SEL_W:0]   outsel,
    input  logic             out_en_n,
    input  logic [SEL_W:0]   loadsel,
    input  logic             load_en_n,
    input  logic [SEL_W-1:0] arg_l,
    input  logic [SEL_W-1:0] arg_r,
    input  logic             arg_r_zero,
    input  logic [2:0]       op,
    input  logic             alt,
    input  logic             cin,
    input  logic             calcf_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       fout
);

    localparam int unsigned SHC_W = $clog2(WIDTH);
    localparam int unsigned SRC_W = SEL_W + 1;
    localparam int unsigned PRD_W = 2 * WIDTH;

    localparam logic [SRC_W-1:0] SEL_RESULT = SRC_W'(NREGS);
    localparam logic [SRC_W-1:0] SEL_FLAGS  = SRC_W'(NREGS + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_LOG = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_SH  = 3'd3;
    localparam logic [2:0] OP_ROT = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_SHN = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   busy_q, done_q;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;

    logic [WIDTH-1:0] l_q, r_q;
    logic [2:0]       op_q;
    logic             alt_q, cin_q, calcf_n_q;
    logic [SHC_W-1:0] cnt_q;
    logic [PRD_W-1:0] acc_q, mcand_q;
    logic [WIDTH-1:0] mplier_q, sh_q;

    logic             accept_c, last_c, flag_load_c, reg_load_c;
    logic [WIDTH-1:0] opnd_l_c, opnd_r_c;
    logic [SHC_W-1:0] n_c, cnt_init_c;
    logic [PRD_W-1:0] acc_nx_c;
    logic [WIDTH-1:0] sh_nx_c;
    logic             sh_out_c;
    logic [WIDTH-1:0] rr_c, fin_res_c, bus_src_c;
    logic [WIDTH:0]   sum_c;
    logic             fin_c_c, fin_v_c;
    logic [3:0]       fin_flags_c;

    // Operand fetch and iteration count for a newly accepted op
    assign opnd_l_c = regs_q[arg_l];
    assign opnd_r_c = arg_r_zero ? '0 : regs_q[arg_r];
    assign n_c      = opnd_r_c[SHC_W-1:0];

    always_comb begin
        cnt_init_c = '0;
        case (op)
            OP_MUL:  cnt_init_c = SHC_W'(WIDTH - 1);
            OP_SHN:  cnt_init_c = (n_c == '0) ? '0 : n_c - SHC_W'(1);
            default: cnt_init_c = '0;
        endcase
    end

    assign last_c      = (state_q == S_RUN) && (cnt_q == '0);
    assign flag_load_c = !load_en_n && (loadsel == SEL_FLAGS);
    assign reg_load_c  = !load_en_n && (loadsel < SEL_RESULT);

    // FSM next state
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    accept_c = 1'b1;
                end
            end
            S_RUN:   if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    // One shift-add / one-bit-shift step per RUN cycle
    assign acc_nx_c = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign sh_nx_c  = alt_q ? {1'b0, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], 1'b0};
    assign sh_out_c = alt_q ? sh_q[0] : sh_q[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            l_q       <= '0;
            r_q       <= '0;
            op_q      <= '0;
            alt_q     <= 1'b0;
            cin_q     <= 1'b0;
            calcf_n_q <= 1'b1;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            sh_q      <= '0;
        end else if (accept_c) begin
            l_q       <= opnd_l_c;
            r_q       <= opnd_r_c;
            op_q      <= op;
            alt_q     <= alt;
            cin_q     <= cin;
            calcf_n_q <= calcf_n;
            cnt_q     <= cnt_init_c;
            acc_q     <= '0;
            mcand_q   <= PRD_W'(opnd_l_c);
            mplier_q  <= opnd_r_c;
            sh_q      <= opnd_l_c;
        end else if (state_q == S_RUN) begin
            acc_q    <= acc_nx_c;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            sh_q     <= sh_nx_c;
            if (cnt_q != '0) cnt_q <= cnt_q - SHC_W'(1);
        end
    end

    // Final result and flags, valid in the last RUN cycle
    always_comb begin
        rr_c      = alt_q ? ~r_q : r_q;
        sum_c     = {1'b0, l_q} + {1'b0, rr_c} + (WIDTH + 1)'(cin_q);
        fin_res_c = l_q;
        fin_c_c   = 1'b0;
        fin_v_c   = 1'b0;
        case (op_q)
            OP_ADD: begin
                fin_res_c = sum_c[WIDTH-1:0];
                fin_c_c   = sum_c[WIDTH];
                fin_v_c   = (l_q[WIDTH-1] == rr_c[WIDTH-1]) && (sum_c[WIDTH-1] != l_q[WIDTH-1]);
            end
            OP_LOG: fin_res_c = alt_q ? (l_q | r_q) : (l_q & r_q);
            OP_XOR: fin_res_c = alt_q ? ~l_q : (l_q ^ r_q);
            OP_SH, OP_ROT: begin
                if (alt_q) begin
                    fin_res_c = {cin_q, l_q[WIDTH-1:1]};
                    fin_c_c   = l_q[0];
                end else begin
                    fin_res_c = {l_q[WIDTH-2:0], cin_q};
                    fin_c_c   = l_q[WIDTH-1];
                end
            end
            OP_MUL: begin
                fin_res_c = acc_nx_c[WIDTH-1:0];
                fin_c_c   = |acc_nx_c[PRD_W-1:WIDTH];
            end
            OP_SHN: begin
                if (r_q[SHC_W-1:0] != '0) begin
                    fin_res_c = sh_nx_c;
                    fin_c_c   = sh_out_c;
                end
            end
            default: fin_res_c = l_q;
        endcase
        fin_flags_c = {fin_res_c[WIDTH-1], fin_v_c, (fin_res_c == '0), fin_c_c};
    end

    // Architectural state; a bus flags load beats the op's flag writeback
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_q <= '0;
            flags_q  <= '0;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            if (last_c) result_q <= fin_res_c;
            if (flag_load_c) begin
                flags_q <= main_bus[3:0];
            end else if (last_c && !calcf_n_q) begin
                flags_q <= fin_flags_c;
            end
            if (reg_load_c) regs_q[loadsel[SEL_W-1:0]] <= main_bus;
        end
    end

    always_comb begin
        bus_src_c = '0;
        if (outsel < SEL_RESULT) begin
            bus_src_c = regs_q[outsel[SEL_W-1:0]];
        end else if (outsel == SEL_RESULT) begin
            bus_src_c = result_q;
        end else if (outsel == SEL_FLAGS) begin
            bus_src_c = WIDTH'(flags_q);
        end
    end

    assign main_bus = (rst && !out_en_n) ? bus_src_c : {WIDTH{1'bz}};

    assign busy = busy_q;
    assign done = done_q;
    assign fout = flags_q;

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Randomised scoreboard bench for alu_regfile_seq (8x4 instance) plus a 16x8 instance.
module tb_alu_regfile_seq;

    localparam int NR = 4;

    logic       clk = 1'b0;
    logic       rst;
    wire  [7:0] bus;
    logic [7:0] tb_bus;
    logic       tb_drv;
    logic [2:0] outsel, loadsel, op;
    logic       out_en_n, load_en_n, arg_r_zero, alt, cin, calcf_n, start;
    logic [1:0] arg_l, arg_r;
    logic       busy, done;
    logic [3:0] fout;

    wire  [15:0] bus16;
    logic [15:0] tb_bus16;
    logic        tb_drv16;
    logic [3:0]  outsel16, loadsel16;
    logic [2:0]  op16, arg_l16, arg_r16;
    logic        out_en_n16, load_en_n16, arg_r_zero16, alt16, cin16, calcf_n16, start16;
    logic        busy16, done16;
    logic [3:0]  fout16;

    typedef struct {
        int res;
        int flg;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   mregs [NR];
    int   mflags, mres;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    assign bus   = tb_drv   ? tb_bus   : 8'hzz;
    assign bus16 = tb_drv16 ? tb_bus16 : 16'hzzzz;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_regfile_seq #(.WIDTH(8), .NREGS(4), .SEL_W(2)) u_dut (
        .clk(clk), .rst(rst), .main_bus(bus), .outsel(outsel), .out_en_n(out_en_n),
        .loadsel(loadsel), .load_en_n(load_en_n), .arg_l(arg_l), .arg_r(arg_r),
        .arg_r_zero(arg_r_zero), .op(op), .alt(alt), .cin(cin), .calcf_n(calcf_n),
        .start(start), .busy(busy), .done(done), .fout(fout)
    );

    alu_regfile_seq #(.WIDTH(16), .NREGS(8), .SEL_W(3)) u_dut16 (
        .clk(clk), .rst(rst), .main_bus(bus16), .outsel(outsel16), .out_en_n(out_en_n16),
        .loadsel(loadsel16), .load_en_n(load_en_n16), .arg_l(arg_l16), .arg_r(arg_r16),
        .arg_r_zero(arg_r_zero16), .op(op16), .alt(alt16), .cin(cin16), .calcf_n(calcf_n16),
        .start(start16), .busy(busy16), .done(done16), .fout(fout16)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: result, flags {N,V,Z,C} and start->done latency
    task automatic model(input int opc, input int a, input int c, input int l, input int r,
                         output int res, output int flg, output int lat);
        int rr, s, t, ls, rs, n, p, cf, vf;
        cf = 0; vf = 0; res = 0; lat = 2;
        case (opc)
            0: begin
                rr  = a ? 255 - r : r;
                s   = l + rr + c;
                res = s % 256;
                cf  = s / 256;
                ls  = (l > 127) ? l - 256 : l;
                rs  = (rr > 127) ? rr - 256 : rr;
                t   = ls + rs + c;
                vf  = (t > 127 || t < -128) ? 1 : 0;
            end
            1: res = a ? (l | r) : (l & r);
            2: res = a ? (255 - l) : (l ^ r);
            3, 4: begin
                if (a == 0) begin res = ((l * 2) + c) % 256; cf = l / 128; end
                else begin res = (l / 2) + c * 128; cf = l % 2; end
            end
            5: begin
                p = l * r; res = p % 256; cf = (p >= 256) ? 1 : 0; lat = 9;
            end
            6: begin
                n = r % 8;
                lat = ((n == 0) ? 1 : n) + 1;
                if (n == 0) res = l;
                else if (a == 0) begin res = (l << n) % 256; cf = (l >> (8 - n)) % 2; end
                else begin res = l >> n; cf = (l >> (n - 1)) % 2; end
            end
            default: res = l;
        endcase
        flg = ((res >= 128) ? 8 : 0) + vf * 4 + ((res == 0) ? 2 : 0) + cf;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        start = 1'b0; load_en_n = 1'b1; loadsel = 3'd4;
        out_en_n = 1'b0; outsel = 3'd4; tb_drv = 1'b0;
    endtask

    task automatic bus_load(input int sel, input int val);
        tb_drv = 1'b1; tb_bus = 8'(val); out_en_n = 1'b1;
        loadsel = 3'(sel); load_en_n = 1'b0;
    endtask

    task automatic load(input int sel, input int val);
        bus_load(sel, val);
        nxt();
        idle();
        if (sel < NR) mregs[sel] = val % 256;
        else if (sel == NR + 1) mflags = val % 16;
    endtask

    task automatic rd(input int sel, input int exp, input string nm);
        outsel = 3'(sel); out_en_n = 1'b0;
        #1;
        chk(nm, int'(bus), exp);
        outsel = 3'd4;
    endtask

    // Issue an op; expected response goes to the scoreboard, optional mid-op disturbances
    task automatic run_op(input int opc, input int a, input int c, input int cf, input int al,
                          input int ar, input int rz, input int ign, input int ovw, input int col);
        int   l, r, res, flg, lat, colv, v;
        exp_t e;
        l = mregs[al];
        r = rz ? 0 : mregs[ar];
        model(opc, a, c, l, r, res, flg, lat);
        colv  = int'($urandom_range(15, 0));
        e.res = res;
        e.flg = col ? colv : ((cf == 0) ? flg : mflags);
        e.cyc = cyc + lat;
        sb.push_back(e);
        op = 3'(opc); alt = 1'(a); cin = 1'(c); calcf_n = 1'(cf);
        arg_l = 2'(al); arg_r = 2'(ar); arg_r_zero = 1'(rz); start = 1'b1;
        nxt();
        start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            arg_l = 2'($urandom); arg_r = 2'($urandom);
            if (k == 1 && ign != 0) begin start = 1'b1; op = 3'($urandom); end
            if (k == 1 && ovw != 0 && lat > 2) begin
                v = int'($urandom_range(255, 0));
                bus_load(al, v);
                mregs[al] = v;
            end
            if (k == lat - 1 && col != 0) bus_load(NR + 1, colv);
            nxt();
            idle();
        end
        mflags = e.flg;
        mres   = res;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("mon_result", int'(bus), e.res);
                chk("mon_flags", int'(fout), e.flg);
                chk("mon_done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int o, a, c, cf, al, ar, rz;
        rst = 1'b0; idle();
        op = '0; alt = 0; cin = 0; calcf_n = 1; arg_l = 0; arg_r = 0; arg_r_zero = 0;
        tb_bus = '0; tb_drv16 = 0; tb_bus16 = '0; outsel16 = 4'd8; out_en_n16 = 1;
        loadsel16 = 4'd8; load_en_n16 = 1; op16 = '0; arg_l16 = '0; arg_r16 = '0;
        arg_r_zero16 = 0; alt16 = 0; cin16 = 0; calcf_n16 = 1; start16 = 0;
        for (int i = 0; i < NR; i++) mregs[i] = 0;
        mflags = 0; mres = 0;
        nxt(); nxt();
        rst = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fout", int'(fout), 0);
        rd(6, 0, "unused_outsel");

        // Reset mid-MUL aborts with no writeback
        for (int i = 0; i < NR; i++) load(i, 8'hFF);
        load(NR + 1, 15);
        op = 3'd5; arg_l = 0; arg_r = 1; arg_r_zero = 0; calcf_n = 0; start = 1;
        nxt(); start = 0;
        nxt(); nxt(); nxt();
        rst = 1'b0;
        nxt();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) mregs[i] = 0;
        mflags = 0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_fout", int'(fout), 0);
        for (int i = 0; i < NR; i++) rd(i, 0, "abort_reg");
        rd(NR, 0, "abort_result");
        rd(NR + 1, 0, "abort_flags");
        repeat (12) nxt();

        // Directed ADD/SUB, MUL, SHN
        load(0, 8'h7F); load(1, 8'h01);
        run_op(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        rd(NR, 8'h80, "add_result"); chk("add_flags", int'(fout), 4'hC);
        run_op(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        rd(NR, 8'h00, "sub_result"); chk("sub_flags", int'(fout), 4'h3);
        load(0, 8'h0F); load(1, 8'h11);
        run_op(5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        rd(NR, 8'hFF, "mul_result"); chk("mul_flags", int'(fout), 4'h8);
        load(0, 8'h10); load(1, 8'h10);
        run_op(5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        rd(NR, 8'h00, "mul_ovf_result"); chk("mul_ovf_flags", int'(fout), 4'h3);
        load(0, 8'hB4); load(1, 8'h03);
        run_op(6, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        rd(NR, 8'h16, "shn_result"); chk("shn_flags", int'(fout), 4'h1);
        load(1, 8'h00);
        run_op(6, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        rd(NR, 8'hB4, "shn0_result"); chk("shn0_flags", int'(fout), 4'h8);

        // Collisions: ignored start, operand overwrite, flags load vs writeback
        load(0, 8'h03); load(1, 8'h05);
        run_op(5, 0, 0, 0, 0, 1, 0, 1, 1, 1);
        rd(NR, 8'h0F, "collide_result");
        chk("collide_flags", int'(fout), mflags);
        rd(0, mregs[0], "overwritten_reg");

        // Self-capture and no-op load codes
        loadsel = 3'd2; load_en_n = 0; outsel = 3'd2; out_en_n = 0;
        nxt(); idle();
        rd(2, mregs[2], "self_capture");
        load(NR, 8'h5A); load(7, 8'hA5);
        for (int i = 0; i < NR; i++) rd(i, mregs[i], "noop_load_reg");
        rd(NR + 1, mflags, "noop_load_flags");

        // Randomised ops interleaved with bus traffic
        for (int it = 0; it < 80; it++) begin
            load(int'($urandom_range(7, 0)), int'($urandom_range(255, 0)));
            load(int'($urandom_range(3, 0)), int'($urandom_range(255, 0)));
            o  = int'($urandom_range(6, 0)); a = int'($urandom_range(1, 0));
            c  = int'($urandom_range(1, 0)); cf = int'($urandom_range(1, 0));
            al = int'($urandom_range(3, 0)); ar = int'($urandom_range(3, 0));
            rz = ($urandom_range(3, 0) == 0) ? 1 : 0;
            run_op(o, a, c, cf, al, ar, rz, ($urandom_range(3, 0) == 0) ? 1 : 0,
                   ($urandom_range(3, 0) == 0) ? 1 : 0, ($urandom_range(3, 0) == 0) ? 1 : 0);
            rd(NR, mres, "rand_result");
            rd(NR + 1, mflags, "rand_flags_bus");
            al = int'($urandom_range(3, 0));
            rd(al, mregs[al], "rand_reg");
        end

        // Wide instance: reg 7 load/readback, no drive when disabled, arg_r_zero ADD
        chk("w16_rst_fout", int'(fout16), 0);
        chk("w16_rst_busy", int'(busy16), 0);
        tb_drv16 = 1; tb_bus16 = 16'hA5C3; loadsel16 = 4'd7; load_en_n16 = 0;
        nxt();
        load_en_n16 = 1; tb_drv16 = 0; outsel16 = 4'd7; out_en_n16 = 0;
        #1 chk("w16_reg7", int'(bus16), 16'hA5C3);
        out_en_n16 = 1; tb_drv16 = 1; tb_bus16 = 16'h5A3C;
        #1 chk("w16_no_drive", int'(bus16), 16'h5A3C);
        tb_drv16 = 0;
        arg_l16 = 3'd7; arg_r16 = 3'd0; arg_r_zero16 = 1; op16 = 3'd0;
        alt16 = 0; cin16 = 0; calcf_n16 = 0; start16 = 1;
        nxt();
        start16 = 0; outsel16 = 4'd8; out_en_n16 = 0;
        nxt();
        chk("w16_done", int'(done16), 1);
        chk("w16_result", int'(bus16), 16'hA5C3);
        chk("w16_flags", int'(fout16), 4'h8);
        nxt();
        chk("w16_done_pulse", int'(done16), 0);

        repeat (3) nxt();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
